// File: rtl/i17998_logic_cone.sv
// i17998_logic_cone: fixed-function sequential cone that drives net I17998.
// Front end:   a = ~(N0 & N1), b = ~(N2 | N3), c = a ^ N4
// State chain: q1 <= c, q2 <= b | q1, q3 <= q1 & ~q2 (sync active-high reset)
// Output:      out = q3 | (q2 & N4 & ~N0), combinational with no output flop
module i17998_logic_cone (
  input  logic N0,
  input  logic N1,
  input  logic N2,
  input  logic N3,
  input  logic N4,
  input  logic CK,
  input  logic reset,
  output logic out
);

  localparam int STAGES = 3;

  logic a, b, c;
  logic q2_n, n0_n, fwd_t;
  logic [STAGES-1:0] state_d, state_q;

  // Front end: NAND / NOR / XOR
  nand g_a (a, N0, N1);
  nor  g_b (b, N2, N3);
  xor  g_c (c, a, N4);

  // Next state. Every flop samples the pre-edge state, so all three update together.
  assign state_d[0] = c;
  or   g_d2  (state_d[1], b, state_q[0]);
  not  g_nq2 (q2_n, state_q[1]);
  and  g_d3  (state_d[2], state_q[0], q2_n);

  // State flops, each with its own reset mux
  for (genvar i = 0; i < STAGES; i++) begin : g_ff
    i17998_logic_cone_dff u_dff (
      .clk_i (CK),
      .rst_i (reset),
      .d_i   (state_d[i]),
      .q_o   (state_q[i])
    );
  end

  // Output gate. The N4 & ~N0 term reaches out with zero latency, gated by q2.
  not g_n0n (n0_n, N0);
  and g_fwd (fwd_t, state_q[1], N4, n0_n);
  or  g_out (out, state_q[2], fwd_t);

endmodule

// D flop with a synchronous active-high reset mux in front of it
module i17998_logic_cone_dff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic q_d, q_q;

  // Reset has priority over the data input
  always_comb begin
    q_d = d_i;
    if (rst_i) q_d = 1'b0;
  end

  // Storage element
  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: tb/tb_i17998_logic_cone.sv
// Testbench for i17998_logic_cone: directed scenarios, a 32-pattern sweep,
// and random vectors, all checked against a behavioural model of the cone.
module tb_i17998_logic_cone;

  logic N0, N1, N2, N3, N4, CK, reset, out;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: one bit per flop, plus a flag set once a reset edge has been seen
  bit m1, m2, m3, mvalid;
  logic [4:0] cur_p;

  i17998_logic_cone dut (
    .N0(N0), .N1(N1), .N2(N2), .N3(N3), .N4(N4),
    .CK(CK), .reset(reset), .out(out)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Pattern bit 4 is N0 and bit 0 is N4
  function automatic bit model_out(input logic [4:0] p);
    bit n0, n4;
    n0 = p[4];
    n4 = p[0];
    return m3 || (m2 && n4 && !n0);
  endfunction

  task automatic model_edge(input logic [4:0] p, input logic r);
    bit a, b, c, n1v, n2v, n3v;
    n1v = p[3]; n2v = p[2]; n3v = p[1];
    a = !(p[4] && n1v);
    b = !(n2v || n3v);
    c = (a != p[0]);
    if (r) begin
      m1 = 0; m2 = 0; m3 = 0; mvalid = 1;
    end else begin
      m3 = m1 && !m2;
      m2 = b || m1;
      m1 = c;
    end
  endtask

  task automatic chk(input string tag, input logic exp);
    vectors++;
    assert (out === exp) else begin
      miscompares++;
      $error("FAIL %s out=%b expected=%b pattern=%b", tag, out, exp, cur_p);
    end
  endtask

  // One cycle: drive at negedge, check before the edge, clock, check after the edge
  task automatic step(input logic [4:0] p, input logic r, input string tag);
    @(negedge CK);
    cur_p = p;
    {N0, N1, N2, N3, N4} = p;
    reset = r;
    #1;
    if (mvalid) chk({tag, "_pre"}, model_out(p));
    @(posedge CK);
    model_edge(p, r);
    #1;
    chk({tag, "_post"}, model_out(p));
  endtask

  initial begin
    mvalid = 0; m1 = 0; m2 = 0; m3 = 0;
    {N0, N1, N2, N3, N4} = 5'b11111;
    reset = 1'b1;
    cur_p = 5'b11111;

    // Reset held for two edges with N = 11111
    step(5'b11111, 1, "rst1"); chk("rst1_zero", 1'b0);
    step(5'b11111, 1, "rst2"); chk("rst2_zero", 1'b0);

    // N = 00000 held: out stays 0
    step(5'b00000, 0, "p0_e1"); chk("p0_e1_c", 1'b0);
    step(5'b00000, 0, "p0_e2"); chk("p0_e2_c", 1'b0);
    step(5'b00000, 0, "p0_e3"); chk("p0_e3_c", 1'b0);

    // N = 00001: out = 1 right after the first edge and stays there
    step(5'b00001, 1, "rst_b");
    step(5'b00001, 0, "p1_e1"); chk("p1_e1_c", 1'b1);
    step(5'b00001, 0, "p1_e2"); chk("p1_e2_c", 1'b1);

    // N = 00100: single-cycle pulse on the second edge
    step(5'b00100, 1, "rst_c");
    step(5'b00100, 0, "p4_e1"); chk("p4_e1_c", 1'b0);
    step(5'b00100, 0, "p4_e2"); chk("p4_e2_c", 1'b1);
    step(5'b00100, 0, "p4_e3"); chk("p4_e3_c", 1'b0);
    step(5'b00100, 0, "p4_e4"); chk("p4_e4_c", 1'b0);

    // Same, with reset asserted before the third edge
    step(5'b00100, 1, "rst_d");
    step(5'b00100, 0, "p4r_e1"); chk("p4r_e1_c", 1'b0);
    step(5'b00100, 0, "p4r_e2"); chk("p4r_e2_c", 1'b1);
    step(5'b00100, 1, "p4r_e3"); chk("p4r_e3_c", 1'b0);
    step(5'b00100, 1, "p4r_e4"); chk("p4r_e4_c", 1'b0);

    // Sweep all 32 patterns from reset, one per clock
    step(5'b00000, 1, "rst_sw");
    for (int i = 0; i < 32; i++) step(5'(i), 0, $sformatf("sweep%0d", i));

    // Random patterns with occasional reset
    for (int i = 0; i < 300; i++)
      step(5'($urandom_range(31)), ($urandom_range(15) == 0), $sformatf("rnd%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case the sequence above never completes
  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
